// File: rtl/instr_encoder_if.sv
// Handshake bundle between the instruction source and the encoder, plus the IM write port.
// master = instruction source / IM model side, slave = encoder side.
interface instr_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [25:0]       in_imm;
  logic              im_we;
  logic              im_ready;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic [ADDR_W:0]   wr_cnt;
  logic              err;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, im_ready,
    input  in_ready, im_we, im_addr, im_wdata, wr_cnt, err
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, im_ready,
    output in_ready, im_we, im_addr, im_wdata, wr_cnt, err
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes symbolic instructions into MIPS words, buffers them in a DEPTH-word FIFO and streams
// them to IM at consecutive addresses; one cycle from accept to im_we, in_ready is registered-full only.
module instr_encoder #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4
) (
  input logic             clk,
  input logic             reset,
  instr_encoder_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0]       r_wptr;
  logic [PW:0]       r_rptr;
  logic [31:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_wr_cnt;
  logic              r_err;

  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_legal;
  logic [31:0] w_word;

  // Full/empty decode only from registered pointers, so in_ready never sees im_ready.
  assign w_full   = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_empty  = (r_wptr == r_rptr);
  assign w_accept = bus.in_valid && !w_full;
  assign w_push   = w_accept && w_legal;
  assign w_pop    = !w_empty && bus.im_ready;

  always_comb begin
    w_legal = 1'b1;
    w_word  = 32'h0;
    unique case (bus.in_op)
      5'd0:  w_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100001};
      5'd1:  w_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100011};
      5'd14: w_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b101011};
      5'd13: w_word = {6'b000000, 5'd0, bus.in_rt, bus.in_rd, bus.in_shamt, 6'b000000};
      5'd7:  w_word = {6'b000000, bus.in_rs, 5'd0, 5'd0, 5'd0, 6'b001000};
      5'd16: w_word = {6'b000000, bus.in_rs, 5'd0, bus.in_rd, 5'd0, 6'b001001};
      5'd2:  w_word = {6'b001101, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      5'd3:  w_word = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      5'd4:  w_word = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      5'd5:  w_word = {6'b000100, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      5'd8:  w_word = {6'b001111, 5'd0, bus.in_rt, bus.in_imm[15:0]};
      5'd9:  w_word = {6'b100000, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      5'd10: w_word = {6'b101000, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      5'd11: w_word = {6'b100001, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      5'd12: w_word = {6'b101001, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      5'd15: w_word = {6'b001000, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      5'd17: w_word = {6'b000010, bus.in_imm};
      5'd6:  w_word = {6'b000011, bus.in_imm};
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_addr   <= '0;
      r_wr_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_addr <= r_addr + 1'b1;
        if (r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + 1'b1;
      end
      if (w_accept && !w_legal) r_err <= 1'b1;
    end
  end

  // Storage needs no reset: slots are only read between a push and its pop.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[PW-1:0]] <= w_word;
  end

  assign bus.in_ready = !w_full;
  assign bus.im_we    = !w_empty;
  assign bus.im_addr  = r_addr;
  assign bus.im_wdata = w_empty ? 32'h0 : r_mem[r_rptr[PW-1:0]];
  assign bus.wr_cnt   = r_wr_cnt;
  assign bus.err      = r_err;
endmodule
